ram_ctrl: RTL

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ram_ctrl.sv
// Byte-writable single-port RAM with a power-up/reset clear sweep, registered
// read port with a valid pulse, sticky access-while-busy error and a byte LED mux.
module ram_ctrl #(
  parameter  int                ADDR_W   = 6,
  parameter  int                DATA_W   = 32,
  parameter  logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int                NB       = DATA_W / 8,
  localparam int                SEL_W    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Write,
  input  logic              Mem_Read,
  input  logic [NB-1:0]     Byte_En,
  input  logic [DATA_W-1:0] Data_In,
  input  logic [SEL_W-1:0]  MUX,
  input  logic              Clr_Err,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Rd_Valid,
  output logic              Busy,
  output logic              Err,
  output logic [7:0]        LED
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_err;

  logic              w_clearing;
  logic              w_access;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [NB-1:0]     w_wr_be;
  logic [7:0]        w_bytes [NB];
  logic [7:0]        w_led;

  assign w_clearing = (r_state == CLEAR);
  assign w_access   = Mem_Write | Mem_Read;
  // The sweep owns the write port; user strobes cannot reach the array meanwhile.
  assign w_wr_addr  = w_clearing ? r_clr_cnt : Mem_Addr;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      assign w_wr_be[gi]          = w_clearing | (Mem_Write & Byte_En[gi]);
      assign w_wr_data[gi*8 +: 8] = w_clearing ? INIT_VAL[gi*8 +: 8] : Data_In[gi*8 +: 8];
      assign w_bytes[gi]          = r_data_out[gi*8 +: 8];
    end
  endgenerate

  // Array kept free of reset so it maps onto block RAM with byte write enables.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_wr_be[b]) begin
        r_mem[w_wr_addr][b*8 +: 8] <= w_wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_cnt  <= '0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (&r_clr_cnt) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end
        end
        READY: begin
          // Non-blocking read of the array gives read-first on a same-address write.
          if (Mem_Read) begin
            r_data_out <= r_mem[Mem_Addr];
            r_rd_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_busy  <= 1'b1;
        end
      endcase

      if (w_clearing && w_access) begin
        r_err <= 1'b1;
      end else if (Clr_Err) begin
        r_err <= 1'b0;
      end
    end
  end

  // Select codes beyond the last byte fall through to zero.
  always_comb begin
    w_led = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (MUX == SEL_W'(b)) begin
        w_led = w_bytes[b];
      end
    end
  end

  assign Data_Out = r_data_out;
  assign Rd_Valid = r_rd_valid;
  assign Busy     = r_busy;
  assign Err      = r_err;
  assign LED      = w_led;

endmodule
